// File: rtl/risc_pkg.sv
// Shared definitions for the fetch front end: widths, reset vector and fetch FSM states.
package risc_pkg;

  localparam int              ADDR_W    = 16;
  localparam int              INSTR_W   = 16;
  localparam logic [15:0]     RESET_PC  = 16'h0000;
  localparam int              PC_STEP   = 2;
  localparam logic [15:0]     NOP_INSTR = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage : risc_pkg

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect target (forced even), sequential increment, or hold.
// Also flags odd redirect targets.
module pc_next_sel #(
  parameter int ADDR_W  = 16,
  parameter int PC_STEP = 2
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc_inc,
  output logic              misalign
);

  // Sequential address wraps modulo 2^ADDR_W by construction.
  assign pc_inc   = pc + ADDR_W'(PC_STEP);
  assign misalign = redirect_valid & redirect_pc[0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = {redirect_pc[ADDR_W-1:1], 1'b0};
    end else if (advance) begin
      pc_next = pc_inc;
    end
  end

endmodule : pc_next_sel

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory and
// fills the IF/ID register, honouring redirect > stall > flush > normal fetch.
module instruction_fetch_unit
  import risc_pkg::*;
#(
  parameter int                ADDR_W   = risc_pkg::ADDR_W,
  parameter int                INSTR_W  = risc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(risc_pkg::RESET_PC),
  parameter int                PC_STEP  = risc_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_next,
  output logic               misalign_err,
  output logic [15:0]        fetch_count
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
  logic               advance, load, bubble, misalign;

  assign imem_pc = pc_q;

  pc_next_sel #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP)
  ) u_pc_next_sel (
    .pc             (pc_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .pc_next        (pc_d),
    .pc_inc         (pc_inc),
    .misalign       (misalign)
  );

  // A redirect seen while idle only moves the PC; it also keeps the unit idle that cycle.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    load    = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bubble = 1'b1;
        if (fetch_en && !redirect_valid) state_d = RUN;
      end
      RUN: begin
        if (!fetch_en) begin
          state_d = IDLE;
          bubble  = 1'b1;
        end else if (redirect_valid) begin
          bubble = 1'b1;
        end else if (stall) begin
          // hold everything
        end else if (flush) begin
          bubble  = 1'b1;
          advance = 1'b1;
        end else begin
          load    = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from
  // the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      if_id_valid   <= 1'b0;
      if_id_instr   <= INSTR_W'(NOP_INSTR);
      if_id_pc      <= '0;
      if_id_pc_next <= '0;
      misalign_err  <= 1'b0;
      fetch_count   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (misalign) misalign_err <= 1'b1;
      if (bubble) begin
        if_id_valid <= 1'b0;
        if_id_instr <= INSTR_W'(NOP_INSTR);
      end else if (load) begin
        if_id_valid   <= 1'b1;
        if_id_instr   <= imem_instr;
        if_id_pc      <= pc_q;
        if_id_pc_next <= pc_inc;
      end
      if (load && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: the driver applies stimulus and queues the model's expected
// post-edge state; an independent monitor pops and compares after every rising edge.
module tb_instruction_fetch_unit;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_next;
  logic        misalign_err;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_next  (if_id_pc_next),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  // Byte-addressed little-endian memory, read combinationally.
  logic [7:0]  mem [65536];
  logic [15:0] imem_pc_hi;
  assign imem_pc_hi = imem_pc + 16'd1;
  assign imem_instr = {mem[imem_pc_hi], mem[imem_pc]};

  typedef struct packed {
    logic [15:0] pc;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic [15:0] ipc_next;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, described in terms of the architectural behaviour.
  int unsigned m_pc;
  bit          m_running;
  bit          m_valid;
  logic [15:0] m_instr;
  int unsigned m_ipc, m_ipc_next, m_cnt;
  bit          m_err;

  function automatic logic [15:0] word_at(input int unsigned addr);
    return {mem[(addr + 1) % 65536], mem[addr % 65536]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_bubble();
    m_valid = 1'b0;
    m_instr = NOP_INSTR;
  endtask

  task automatic step(input logic r, input logic en, input logic st, input logic fl,
                      input logic rv, input logic [15:0] rpc);
    int unsigned target;
    @(negedge clk);
    rst_n = r; fetch_en = en; stall = st; flush = fl;
    redirect_valid = rv; redirect_pc = rpc;
    target = int'(rpc) & 32'hFFFE;
    if (!r) begin
      m_pc = RESET_PC; m_running = 0; m_valid = 0; m_instr = NOP_INSTR;
      m_ipc = 0; m_ipc_next = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (rv && rpc[0]) m_err = 1;
      if (!m_running) begin
        model_bubble();
        if (rv) m_pc = target;
        else if (en) m_running = 1;
      end else if (!en) begin
        m_running = 0;
        model_bubble();
        if (rv) m_pc = target;
      end else if (rv) begin
        model_bubble();
        m_pc = target;
      end else if (st) begin
        // nothing moves
      end else if (fl) begin
        model_bubble();
        m_pc = (m_pc + PC_STEP) % 65536;
      end else begin
        m_valid    = 1;
        m_instr    = word_at(m_pc);
        m_ipc      = m_pc;
        m_ipc_next = (m_pc + PC_STEP) % 65536;
        m_pc       = m_ipc_next;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    q.push_back('{pc: 16'(m_pc), valid: m_valid, instr: m_instr, ipc: 16'(m_ipc),
                  ipc_next: 16'(m_ipc_next), err: m_err, cnt: 16'(m_cnt)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 16'h0000);
  endtask

  // Monitor: one expected entry per clock once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("imem_pc",       32'(imem_pc),       32'(e.pc));
        check("if_id_valid",   32'(if_id_valid),   32'(e.valid));
        check("if_id_instr",   32'(if_id_instr),   32'(e.instr));
        check("if_id_pc",      32'(if_id_pc),      32'(e.ipc));
        check("if_id_pc_next", 32'(if_id_pc_next), 32'(e.ipc_next));
        check("misalign_err",  32'(misalign_err),  32'(e.err));
        check("fetch_count",   32'(fetch_count),   32'(e.cnt));
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset, then start fetching from RESET_PC.
    step(0, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 16'h0000);
    run(4);
    // Stall held three cycles, then resume.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 16'h0000);
    run(2);
    // Redirect concurrent with stall and flush.
    step(1, 1, 1, 1, 1, 16'h000A);
    run(2);
    // Odd target: aligned down, sticky error.
    step(1, 1, 0, 0, 1, 16'h0007);
    run(2);
    // Address wrap at the top of memory.
    step(1, 1, 0, 0, 1, 16'hFFFE);
    run(3);
    // Flush, then drop and restore fetch_en.
    step(1, 1, 0, 1, 0, 16'h0000);
    run(1);
    step(1, 0, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 1, 16'h0040);
    run(3);
    // Mid-run reset at pc 0x20.
    step(1, 1, 0, 0, 1, 16'h0020);
    step(1, 1, 0, 0, 0, 16'h0000);
    step(0, 1, 1, 1, 1, 16'h1235);
    run(3);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           16'($urandom));
    end

    @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface. Owns the PC, drives the byte address into the combinational 16-bit instruction memory and captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from later pipeline stages.
- Sits between the PC-control logic of EX/ID and the decode stage.

Parameters:
- ADDR_W, 16, width of PC and instruction-memory byte address
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_STEP, 2, byte increment per sequential fetch

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- fetch_en  in  1  start/continue fetching; low holds the unit in IDLE
- imem_pc  out  ADDR_W  byte address to instruction memory, always even
- imem_instr  in  INSTR_W  instruction returned combinationally for imem_pc
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  squash the instruction being fetched this cycle
- redirect_valid  in  1  taken branch/jump
- redirect_pc  in  ADDR_W  redirect target
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  INSTR_W  fetched instruction
- if_id_pc  out  ADDR_W  address of if_id_instr
- if_id_pc_next  out  ADDR_W  if_id_pc + PC_STEP, wrapped
- misalign_err  out  1  sticky; a redirect target had bit0 set
- fetch_count  out  16  saturating count of valid instructions delivered

Behaviour:
- All state updates occur on posedge clk. Reset is sampled synchronously when rst_n=0.
- Reset values:
  - pc = RESET_PC
  - state = IDLE
  - if_id_valid = 0, if_id_instr = 0 (NOP), if_id_pc = 0, if_id_pc_next = 0
  - misalign_err = 0, fetch_count = 0
- imem_pc = pc register (combinational output of the register). Memory read is same-cycle, so fetch latency is 1 cycle from PC to IF/ID.
- FSM:
  - IDLE: if_id_valid forced to 0 and PC held. Go to RUN when fetch_en=1 (PC unchanged on the transition). The first instruction appears in IF/ID the cycle after the first RUN cycle.
  - RUN: go to IDLE when fetch_en=0. In that cycle the IF/ID is loaded with a bubble and the PC is held.
- Per-cycle priority in RUN, highest first: rst_n=0, redirect_valid, stall, flush, normal.
  - redirect: pc <= {redirect_pc[15:1],1'b0}; IF/ID <= bubble (valid=0, instr=0). Redirect wins over stall and flush. If redirect_pc[0]=1, set misalign_err (sticky until reset).
  - stall (no redirect): pc and all IF/ID outputs hold; fetch_count holds.
  - flush (no redirect, no stall): IF/ID <= bubble; pc <= pc + PC_STEP.
  - normal:
    - if_id_instr <= imem_instr
    - if_id_pc <= pc
    - if_id_pc_next <= pc + PC_STEP
    - if_id_valid <= 1
    - pc <= pc + PC_STEP
    - fetch_count++
- Redirect in IDLE: PC is loaded, state stays IDLE.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFE + 2 = 16'h0000, with no error flag.
- fetch_count saturates at 16'hFFFF.
- Reset asserted mid-operation overrides all inputs that cycle.

Decomposition:
- Shared package risc_pkg:
  - NOP_INSTR (16'h0000), RESET_PC, PC_STEP, ADDR_W, INSTR_W
  - fetch_state_t enum {IDLE, RUN}
- One sub-module, pc_next_sel: combinational next-PC mux (redirect / hold / increment) plus the misalign detect. The FSM, IF/ID register and counter stay in the top module.

Test Plan:
- Reset, then fetch_en=1 with memory preloaded at 0..5 -> imem_pc runs 0,0,2,4. if_id_pc runs 0,2 with valid=1 starting the 2nd RUN cycle. if_id_instr = {mem[1],mem[0]}, and so on.
- Stall held 3 cycles at pc=4 -> imem_pc stays 4 and IF/ID unchanged for 3 cycles. fetch_count unchanged. Resumes at 4 and 6 afterwards.
- redirect_valid with redirect_pc=16'h000A concurrent with stall -> next cycle imem_pc=0x000A and if_id_valid=0. The following cycle if_id_pc=0x000A.
- redirect_pc=16'h0007 -> imem_pc=0x0006 and misalign_err=1, which stays 1 until rst_n=0.
- Redirect to 16'hFFFE, run 2 cycles -> if_id_pc=0xFFFE with if_id_pc_next=0x0000, then if_id_pc=0x0000.
- rst_n=0 for one cycle mid-run at pc=0x20 -> next cycle pc=RESET_PC, state IDLE, if_id_valid=0, fetch_count=0.
